// File: rtl/serial2parallel.sv
// Serial-to-parallel receiver: synchronises s_clk/s_clr/s_dat into the clk
// domain, assembles one DATA_BITS word per s_clr-delimited frame and presents
// it on a valid/ready output register with a one-cycle overrun pulse.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for s_clr; s_clk rises ignored
// CLEAR  | s_clr held; counter and shift register forced to 0
// RECV   | shifting one bit per synchronised s_clk rise
// COMMIT | word complete; load data/valid on this cycle, then IDLE
module serial2parallel #(
  parameter int DATA_BITS   = 32,
  parameter bit CODE_ENDIAN = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_clk,
  input  logic                 s_clr,
  input  logic                 s_dat,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 busy,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    RECV   = 2'd2,
    COMMIT = 2'd3
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] s_clk_sync_q;
  logic [SYNC_STAGES-1:0] s_clr_sync_q;
  logic [SYNC_STAGES-1:0] s_dat_sync_q;
  logic                   s_clk_edge_q;
  logic [DATA_BITS-1:0]   shreg_q;
  logic [DATA_BITS-1:0]   shreg_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [DATA_BITS-1:0]   data_q;
  logic                   valid_q;
  logic                   busy_q;
  logic                   overrun_q;

  logic s_clk_s;
  logic s_clr_s;
  logic s_dat_s;
  logic rise_d;

  assign s_clk_s = s_clk_sync_q[SYNC_STAGES-1];
  assign s_clr_s = s_clr_sync_q[SYNC_STAGES-1];
  assign s_dat_s = s_dat_sync_q[SYNC_STAGES-1];
  assign rise_d  = s_clk_s & ~s_clk_edge_q;

  // Equal-depth synchronisers keep the three lines aligned to each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_clk_sync_q <= '0;
      s_clr_sync_q <= '0;
      s_dat_sync_q <= '0;
      s_clk_edge_q <= 1'b0;
    end else begin
      s_clk_sync_q <= {s_clk_sync_q[SYNC_STAGES-2:0], s_clk};
      s_clr_sync_q <= {s_clr_sync_q[SYNC_STAGES-2:0], s_clr};
      s_dat_sync_q <= {s_dat_sync_q[SYNC_STAGES-2:0], s_dat};
      s_clk_edge_q <= s_clk_s;
    end
  end

  // Next shift-register value for one received bit, in the selected bit order.
  always_comb begin
    shreg_d = shreg_q;
    if (CODE_ENDIAN == 1'b0) begin
      shreg_d = {s_dat_s, shreg_q[DATA_BITS-1:1]};
    end else begin
      shreg_d = {shreg_q[DATA_BITS-2:0], s_dat_s};
    end
  end

  // Frame FSM with registered data/valid/busy/overrun outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      busy_q    <= (state_q == CLEAR) || (state_q == RECV);
      overrun_q <= 1'b0;
      // consumption; a commit below takes priority
      if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (s_clr_s) begin
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          cnt_q   <= '0;
          shreg_q <= '0;
          if (!s_clr_s) begin
            state_q <= RECV;
          end
        end
        RECV: begin
          if (s_clr_s) begin
            state_q <= CLEAR;
          end else if (rise_d) begin
            shreg_q <= shreg_d;
            // hold the counter on the last bit so it never wraps in a frame
            if (cnt_q == LAST_BIT) begin
              state_q <= COMMIT;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        COMMIT: begin
          data_q    <= shreg_q;
          valid_q   <= 1'b1;
          overrun_q <= valid_q && !ready;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data    = data_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_serial2parallel.sv
// Bench for serial2parallel: a little-endian and a big-endian instance share
// the serial lines; expected words come from a bit-order model of the link.
module tb_serial2parallel;

  localparam int SYNC = 2;

  logic        clk;
  logic        rst_n;
  logic        s_clk;
  logic        s_clr;
  logic        s_dat;
  logic        ready;
  logic [31:0] data_le;
  logic [31:0] data_be;
  logic        valid_le;
  logic        valid_be;
  logic        busy_le;
  logic        busy_be;
  logic        ovr_le;
  logic        ovr_be;

  int n_assert = 0;
  int n_fail   = 0;

  serial2parallel #(.DATA_BITS(32), .CODE_ENDIAN(1'b0), .SYNC_STAGES(SYNC)) dut_le (
    .clk(clk), .rst_n(rst_n), .s_clk(s_clk), .s_clr(s_clr), .s_dat(s_dat),
    .data(data_le), .valid(valid_le), .ready(ready), .busy(busy_le), .overrun(ovr_le)
  );

  serial2parallel #(.DATA_BITS(32), .CODE_ENDIAN(1'b1), .SYNC_STAGES(SYNC)) dut_be (
    .clk(clk), .rst_n(rst_n), .s_clk(s_clk), .s_clr(s_clr), .s_dat(s_dat),
    .data(data_be), .valid(valid_be), .ready(ready), .busy(busy_be), .overrun(ovr_be)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Word seen by a receiver: i-th bit on the wire lands at position i (LE)
  // or 31-i (BE); the wire order is the word's LSB-first or MSB-first bits.
  function automatic logic [31:0] model(input logic [31:0] w, input bit msb_first, input bit be);
    logic [31:0] r;
    logic        b;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      b = msb_first ? w[31-i] : w[i];
      if (be) r[31-i] = b;
      else    r[i]    = b;
    end
    return r;
  endfunction

  // Clear pulse then nbits bits, 5 clk per s_clk phase; optionally return
  // right after the last rising s_clk edge.
  task automatic send_frame(input logic [31:0] w, input bit msb_first, input int nbits,
                            input bit stop_at_rise);
    @(negedge clk);
    s_clr = 1'b1;
    repeat (6) @(negedge clk);
    s_clr = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      s_dat = msb_first ? w[31-i] : w[i];
      repeat (5) @(negedge clk);
      s_clk = 1'b1;
      if (stop_at_rise && i == nbits - 1) return;
      repeat (5) @(negedge clk);
      s_clk = 1'b0;
    end
  endtask

  // Commit lands SYNC+2 clk edges after the final s_clk rise.
  task automatic finish_commit(input string tag, input logic [31:0] e_le, input logic [31:0] e_be,
                               input logic pre_valid, input logic exp_ovr, input bit raise_ready);
    repeat (SYNC + 1) @(posedge clk);
    @(negedge clk);
    chk({tag, "_pre_valid_le"}, 32'(valid_le), 32'(pre_valid));
    chk({tag, "_pre_valid_be"}, 32'(valid_be), 32'(pre_valid));
    chk({tag, "_busy_le"}, 32'(busy_le), 32'd1);
    chk({tag, "_busy_be"}, 32'(busy_be), 32'd1);
    if (raise_ready) ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_valid_le"}, 32'(valid_le), 32'd1);
    chk({tag, "_valid_be"}, 32'(valid_be), 32'd1);
    chk({tag, "_data_le"}, data_le, e_le);
    chk({tag, "_data_be"}, data_be, e_be);
    chk({tag, "_ovr_le"}, 32'(ovr_le), 32'(exp_ovr));
    chk({tag, "_ovr_be"}, 32'(ovr_be), 32'(exp_ovr));
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_ovr_end_le"}, 32'(ovr_le), 32'd0);
    chk({tag, "_ovr_end_be"}, 32'(ovr_be), 32'd0);
    chk({tag, "_post_valid_le"}, 32'(valid_le), ready ? 32'd0 : 32'd1);
    chk({tag, "_post_valid_be"}, 32'(valid_be), ready ? 32'd0 : 32'd1);
    chk({tag, "_hold_le"}, data_le, e_le);
    chk({tag, "_busy_end_le"}, 32'(busy_le), 32'd0);
    repeat (3) @(negedge clk);
    s_clk = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    logic [31:0] w;
    bit          m;
    rst_n = 1'b0;
    s_clk = 1'b0;
    s_clr = 1'b0;
    s_dat = 1'b0;
    ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_data_le", data_le, 32'd0);
    chk("rst_valid_le", 32'(valid_le), 32'd0);
    chk("rst_busy_be", 32'(busy_be), 32'd0);
    chk("rst_ovr_be", 32'(ovr_be), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // LSB-first frame, ready high
    ready = 1'b1;
    send_frame(32'hA5C30F96, 1'b0, 32, 1'b1);
    finish_commit("lsbfirst", model(32'hA5C30F96, 1'b0, 1'b0), model(32'hA5C30F96, 1'b0, 1'b1),
                  1'b0, 1'b0, 1'b0);

    // MSB-first frame: BE gets the word, LE gets it bit-reversed
    send_frame(32'hA5C30F96, 1'b1, 32, 1'b1);
    finish_commit("msbfirst", model(32'hA5C30F96, 1'b1, 1'b0), model(32'hA5C30F96, 1'b1, 1'b1),
                  1'b0, 1'b0, 1'b0);

    // back-to-back frames with ready low -> overrun on the second
    ready = 1'b0;
    send_frame(32'h00000001, 1'b0, 32, 1'b1);
    finish_commit("b2b_1", model(32'h00000001, 1'b0, 1'b0), model(32'h00000001, 1'b0, 1'b1),
                  1'b0, 1'b0, 1'b0);
    send_frame(32'hFFFFFFFE, 1'b0, 32, 1'b1);
    finish_commit("b2b_2", model(32'hFFFFFFFE, 1'b0, 1'b0), model(32'hFFFFFFFE, 1'b0, 1'b1),
                  1'b1, 1'b1, 1'b0);
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("consume_valid_le", 32'(valid_le), 32'd0);
    chk("consume_valid_be", 32'(valid_be), 32'd0);
    chk("consume_data_le", data_le, 32'hFFFFFFFE);

    // aborted frame after 13 bits, then a full frame
    ready = 1'b0;
    send_frame(32'hCAFEF00D, 1'b0, 13, 1'b0);
    chk("abort_busy_le", 32'(busy_le), 32'd1);
    chk("abort_valid_le", 32'(valid_le), 32'd0);
    chk("abort_valid_be", 32'(valid_be), 32'd0);
    send_frame(32'h12345678, 1'b0, 32, 1'b1);
    finish_commit("after_abort", model(32'h12345678, 1'b0, 1'b0), model(32'h12345678, 1'b0, 1'b1),
                  1'b0, 1'b0, 1'b0);

    // asynchronous reset pulse mid-frame
    send_frame(32'hDEADBEEF, 1'b0, 10, 1'b0);
    chk("pre_rst_busy_le", 32'(busy_le), 32'd1);
    chk("pre_rst_valid_le", 32'(valid_le), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_data_le", data_le, 32'd0);
    chk("arst_data_be", data_be, 32'd0);
    chk("arst_valid_le", 32'(valid_le), 32'd0);
    chk("arst_busy_le", 32'(busy_le), 32'd0);
    chk("arst_busy_be", 32'(busy_be), 32'd0);
    rst_n = 1'b1;
    send_frame(32'hDEADBEEF, 1'b0, 32, 1'b1);
    finish_commit("post_rst", model(32'hDEADBEEF, 1'b0, 1'b0), model(32'hDEADBEEF, 1'b0, 1'b1),
                  1'b0, 1'b0, 1'b0);

    // stray s_clk pulses in IDLE must not commit anything
    for (int k = 0; k < 5; k++) begin
      repeat (5) @(negedge clk);
      s_dat = 1'b1;
      s_clk = 1'b1;
      repeat (5) @(negedge clk);
      s_clk = 1'b0;
    end
    repeat (5) @(negedge clk);
    chk("stray_valid_le", 32'(valid_le), 32'd1);
    chk("stray_data_le", data_le, model(32'hDEADBEEF, 1'b0, 1'b0));
    chk("stray_data_be", data_be, model(32'hDEADBEEF, 1'b0, 1'b1));
    chk("stray_busy_le", 32'(busy_le), 32'd0);

    // commit on the same edge the consumer takes the old word
    send_frame(32'h0000FFFF, 1'b0, 32, 1'b1);
    finish_commit("same_cycle", model(32'h0000FFFF, 1'b0, 1'b0), model(32'h0000FFFF, 1'b0, 1'b1),
                  1'b1, 1'b0, 1'b1);

    // random words in random wire order
    ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      w = $urandom;
      m = 1'($urandom_range(0, 1));
      send_frame(w, m, 32, 1'b1);
      finish_commit("rand", model(w, m, 1'b0), model(w, m, 1'b1), 1'b0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
